alu_op_sequencer: RTL and testbench

//  Sequences each Forth ALU instruction through the operand-select stage.
//  - Accepts one decoded instruction word, then fetches an inline immediate or a memory operand if needed.
//  - Drives the operand-select controls (B_op, Swap, SelectImm) and the latched imm/Mem values.
//  - Pulses wb_en in the single EXEC cycle, when the ALU result is valid.

---
 rtl/alu_op_sequencer.sv | 103 ++++++++++
 tb/tb_alu_op_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Operand-select sequencer for Forth ALU instructions: decodes one instruction,
// fetches an inline immediate or memory operand if needed, then pulses wb_en.
module alu_op_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   input  logic [15:0] instr,
   output logic        instr_ready,
   input  logic        imm_valid,
   input  logic [15:0] imm_data,
   output logic        imm_ready,
   input  logic [15:0] T,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic [1:0]  B_op,
   output logic        Swap,
   output logic        SelectImm,
   output logic [15:0] imm_out,
   output logic [15:0] mem_out,
   output logic [3:0]  alu_fn,
   output logic        wb_en,
   output logic        busy,
   output logic        timeout_err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] IMM  = 2'd1;
   localparam logic [1:0] MEM  = 2'd2;
   localparam logic [1:0] EXEC = 2'd3;

   // Compared against the pre-increment count, so mem_req is high exactly MEM_TIMEOUT cycles.
   localparam logic [3:0] LAST = 4'(MEM_TIMEOUT - 1);

   logic [1:0] state;
   logic [3:0] count;
   logic       unused_bits;

   assign unused_bits = ^instr[7:0];

   // Handshake outputs decode straight from state so async reset drops them immediately.
   assign instr_ready = (state == IDLE);
   assign imm_ready   = (state == IMM);
   assign mem_req     = (state == MEM);
   assign wb_en       = (state == EXEC);
   assign busy        = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         count       <= '0;
         alu_fn      <= '0;
         B_op        <= '0;
         Swap        <= 1'b0;
         SelectImm   <= 1'b0;
         mem_addr    <= '0;
         imm_out     <= '0;
         mem_out     <= '0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (instr_valid) begin
                  alu_fn    <= instr[15:12];
                  B_op      <= instr[11:10];
                  Swap      <= instr[9];
                  SelectImm <= instr[8];
                  mem_addr  <= T;
                  count     <= '0;
                  if (instr[8])
                     state <= IMM;
                  else if (instr[11:10] == 2'b11)
                     state <= MEM;
                  else
                     state <= EXEC;
               end
            end
            IMM: begin
               if (imm_valid) begin
                  imm_out <= imm_data;
                  state   <= EXEC;
               end
            end
            MEM: begin
               if (mem_ack) begin
                  mem_out <= mem_rdata;
                  state   <= EXEC;
               end else if (count == LAST) begin
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end else begin
                  count <= count + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer.
module tb_alu_op_sequencer;

   localparam int unsigned TO = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic [15:0] instr = '0;
   logic        instr_ready;
   logic        imm_valid = 1'b0;
   logic [15:0] imm_data = '0;
   logic        imm_ready;
   logic [15:0] T = '0;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic [1:0]  B_op;
   logic        Swap;
   logic        SelectImm;
   logic [15:0] imm_out;
   logic [15:0] mem_out;
   logic [3:0]  alu_fn;
   logic        wb_en;
   logic        busy;
   logic        timeout_err;

   int total = 0;
   int bad = 0;

   alu_op_sequencer #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
      .imm_valid(imm_valid), .imm_data(imm_data), .imm_ready(imm_ready),
      .T(T), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .B_op(B_op), .Swap(Swap), .SelectImm(SelectImm),
      .imm_out(imm_out), .mem_out(mem_out), .alu_fn(alu_fn),
      .wb_en(wb_en), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL rst_instr_ready got=%0h exp=1", instr_ready); end
      total++; if (imm_ready !== 1'b0) begin bad++; $display("FAIL rst_imm_ready got=%0h exp=0", imm_ready); end
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%0h exp=0", mem_req); end
      total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL rst_wb_en got=%0h exp=0", wb_en); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", busy); end
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout_err got=%0h exp=0", timeout_err); end
      total++; if ({alu_fn, B_op, Swap, SelectImm} !== 8'h00) begin bad++; $display("FAIL rst_ctrl got=%0h exp=0", {alu_fn, B_op, Swap, SelectImm}); end
      total++; if ({mem_addr, imm_out, mem_out} !== 48'h0) begin bad++; $display("FAIL rst_data got=%0h exp=0", {mem_addr, imm_out, mem_out}); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_plain;
      instr = 16'h5400;
      instr_valid = 1'b1;
      total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL plain_ready0 got=%0h exp=1", instr_ready); end
      tick();
      instr_valid = 1'b0;
      total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL plain_ready1 got=%0h exp=0", instr_ready); end
      total++; if (wb_en !== 1'b1) begin bad++; $display("FAIL plain_wb1 got=%0h exp=1", wb_en); end
      total++; if (B_op !== 2'd1) begin bad++; $display("FAIL plain_bop got=%0h exp=1", B_op); end
      total++; if (Swap !== 1'b0) begin bad++; $display("FAIL plain_swap got=%0h exp=0", Swap); end
      total++; if (SelectImm !== 1'b0) begin bad++; $display("FAIL plain_selimm got=%0h exp=0", SelectImm); end
      total++; if (alu_fn !== 4'd5) begin bad++; $display("FAIL plain_fn got=%0h exp=5", alu_fn); end
      tick();
      total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL plain_wb2 got=%0h exp=0", wb_en); end
      total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL plain_ready2 got=%0h exp=1", instr_ready); end
      total++; if ({alu_fn, B_op} !== 6'h15) begin bad++; $display("FAIL plain_hold got=%0h exp=15", {alu_fn, B_op}); end
   endtask

   task automatic test_imm;
      instr = 16'h0100;
      instr_valid = 1'b1;
      imm_valid = 1'b1;
      imm_data = 16'h1111;
      tick();
      instr_valid = 1'b0;
      imm_valid = 1'b0;
      total++; if (imm_ready !== 1'b1) begin bad++; $display("FAIL imm_ready got=%0h exp=1", imm_ready); end
      total++; if (SelectImm !== 1'b1) begin bad++; $display("FAIL imm_selimm got=%0h exp=1", SelectImm); end
      total++; if (B_op !== 2'd0) begin bad++; $display("FAIL imm_bop got=%0h exp=0", B_op); end
      total++; if (imm_out !== 16'h0000) begin bad++; $display("FAIL imm_early got=%0h exp=0000", imm_out); end
      tick();
      total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL imm_wb_c2 got=%0h exp=0", wb_en); end
      tick();
      total++; if (imm_ready !== 1'b1) begin bad++; $display("FAIL imm_ready_c3 got=%0h exp=1", imm_ready); end
      imm_valid = 1'b1;
      imm_data = 16'hBEEF;
      tick();
      imm_valid = 1'b0;
      total++; if (wb_en !== 1'b1) begin bad++; $display("FAIL imm_wb_c4 got=%0h exp=1", wb_en); end
      total++; if (imm_out !== 16'hBEEF) begin bad++; $display("FAIL imm_out got=%0h exp=BEEF", imm_out); end
      tick();
      total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL imm_wb_c5 got=%0h exp=0", wb_en); end
      total++; if (imm_out !== 16'hBEEF) begin bad++; $display("FAIL imm_hold got=%0h exp=BEEF", imm_out); end
      // use_imm together with b_src==3: immediate path, no memory read
      instr = 16'h0D00;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      total++; if ({imm_ready, mem_req} !== 2'b10) begin bad++; $display("FAIL prio_state got=%0b exp=10", {imm_ready, mem_req}); end
      total++; if (B_op !== 2'd3) begin bad++; $display("FAIL prio_bop got=%0h exp=3", B_op); end
      imm_valid = 1'b1;
      imm_data = 16'h0042;
      tick();
      imm_valid = 1'b0;
      total++; if ({wb_en, imm_out} !== {1'b1, 16'h0042}) begin bad++; $display("FAIL prio_exec got=%0h exp=10042", {wb_en, imm_out}); end
      tick();
   endtask

   task automatic test_mem;
      mem_ack = 1'b1;
      mem_rdata = 16'h9999;
      tick();
      mem_ack = 1'b0;
      total++; if (mem_out !== 16'h0000) begin bad++; $display("FAIL mem_ack_idle got=%0h exp=0000", mem_out); end
      total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL mem_ack_idle_state got=%0h exp=1", instr_ready); end
      instr = 16'h2E00;
      T = 16'h1234;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      T = 16'h0000;
      for (int i = 1; i <= 4; i++) begin
         total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL mem_req c%0d got=%0h exp=1", i, mem_req); end
         total++; if (mem_addr !== 16'h1234) begin bad++; $display("FAIL mem_addr c%0d got=%0h exp=1234", i, mem_addr); end
         total++; if ({B_op, Swap, wb_en} !== 4'b1110) begin bad++; $display("FAIL mem_ctrl c%0d got=%0b exp=1110", i, {B_op, Swap, wb_en}); end
         if (i == 4) begin
            mem_ack = 1'b1;
            mem_rdata = 16'hCAFE;
         end
         tick();
      end
      mem_ack = 1'b0;
      total++; if ({wb_en, mem_req} !== 2'b10) begin bad++; $display("FAIL mem_exec got=%0b exp=10", {wb_en, mem_req}); end
      total++; if (mem_out !== 16'hCAFE) begin bad++; $display("FAIL mem_out got=%0h exp=CAFE", mem_out); end
      total++; if (alu_fn !== 4'd2) begin bad++; $display("FAIL mem_fn got=%0h exp=2", alu_fn); end
      tick();
      total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL mem_wb_after got=%0h exp=0", wb_en); end
   endtask

   task automatic test_ack_last;
      instr = 16'h3C00;
      T = 16'h00A0;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      for (int i = 1; i <= TO; i++) begin
         total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL acklast_req c%0d got=%0h exp=1", i, mem_req); end
         if (i == TO) begin
            mem_ack = 1'b1;
            mem_rdata = 16'h5A5A;
         end
         tick();
      end
      mem_ack = 1'b0;
      total++; if (wb_en !== 1'b1) begin bad++; $display("FAIL acklast_wb got=%0h exp=1", wb_en); end
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL acklast_err got=%0h exp=0", timeout_err); end
      total++; if (mem_out !== 16'h5A5A) begin bad++; $display("FAIL acklast_data got=%0h exp=5A5A", mem_out); end
      tick();
   endtask

   task automatic test_timeout;
      instr = 16'h7C00;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      for (int i = 1; i <= TO; i++) begin
         total++; if ({mem_req, wb_en} !== 2'b10) begin bad++; $display("FAIL to_req c%0d got=%0b exp=10", i, {mem_req, wb_en}); end
         tick();
      end
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL to_req_drop got=%0h exp=0", mem_req); end
      total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_err got=%0h exp=1", timeout_err); end
      total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL to_wb got=%0h exp=0", wb_en); end
      total++; if ({instr_ready, busy} !== 2'b10) begin bad++; $display("FAIL to_idle got=%0b exp=10", {instr_ready, busy}); end
      total++; if (mem_out !== 16'h5A5A) begin bad++; $display("FAIL to_mem_out got=%0h exp=5A5A", mem_out); end
      instr = 16'h1400;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      total++; if ({wb_en, timeout_err} !== 2'b11) begin bad++; $display("FAIL to_sticky got=%0b exp=11", {wb_en, timeout_err}); end
      tick();
   endtask

   task automatic test_reset_mid;
      instr = 16'h0C00;
      T = 16'h4444;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rmid_req_pre got=%0h exp=1", mem_req); end
      #2 rst = 1'b1;
      #1;
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rmid_req got=%0h exp=0", mem_req); end
      total++; if ({instr_ready, busy, timeout_err} !== 3'b100) begin bad++; $display("FAIL rmid_flags got=%0b exp=100", {instr_ready, busy, timeout_err}); end
      total++; if ({mem_addr, mem_out, imm_out} !== 48'h0) begin bad++; $display("FAIL rmid_data got=%0h exp=0", {mem_addr, mem_out, imm_out}); end
      total++; if ({alu_fn, B_op, Swap, SelectImm} !== 8'h00) begin bad++; $display("FAIL rmid_ctrl got=%0h exp=0", {alu_fn, B_op, Swap, SelectImm}); end
      tick();
      rst = 1'b0;
      instr = 16'h9400;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      total++; if ({wb_en, alu_fn} !== 5'h19) begin bad++; $display("FAIL rmid_next got=%0h exp=19", {wb_en, alu_fn}); end
      tick();
   endtask

   task automatic test_back_to_back;
      instr = 16'hA400;
      instr_valid = 1'b1;
      tick();
      instr = 16'hB800;
      total++; if ({wb_en, instr_ready, alu_fn} !== 6'h2A) begin bad++; $display("FAIL b2b_c1 got=%0h exp=2A", {wb_en, instr_ready, alu_fn}); end
      tick();
      total++; if ({wb_en, instr_ready, alu_fn} !== 6'h1A) begin bad++; $display("FAIL b2b_c2 got=%0h exp=1A", {wb_en, instr_ready, alu_fn}); end
      tick();
      instr_valid = 1'b0;
      total++; if ({wb_en, alu_fn, B_op} !== 7'h6E) begin bad++; $display("FAIL b2b_c3 got=%0h exp=6E", {wb_en, alu_fn, B_op}); end
      tick();
   endtask

   initial begin
      test_reset();
      test_plain();
      test_imm();
      test_mem();
      test_ack_last();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
